// File: rtl/linvis_pkg.sv
// Shared definitions for the linear LED visualizer: default fixed-point widths,
// the run-sequencing state type and the hue wheel segment boundaries.
package linvis_pkg;

    localparam int LINVIS_W = 6;
    localparam int LINVIS_D = 10;
    localparam int LINVIS_WD = LINVIS_W + LINVIS_D;

    // Hue wheel spans 24 whole units; these are the points where the colour
    // reaches pure red, pure blue and returns to pure yellow.
    localparam int HUE_SPAN   = 24;
    localparam int HUE_RED    = 12;
    localparam int HUE_BLUE   = 18;
    localparam int HUE_YELLOW = 22;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        PRE,
        CALC,
        OUT
    } state_t;

endpackage

// File: rtl/hue_to_rgb.sv
// Combinational map from a W.D hue position in [0, 24) to unscaled 8-bit RGB
// along a yellow -> red -> blue -> yellow wheel.
module hue_to_rgb
    import linvis_pkg::*;
#(
    parameter int W                 = LINVIS_W,
    parameter int D                 = LINVIS_D,
    parameter int yellowToRedSlope  = 21824,
    parameter int redToBlueSlope    = 43648,
    parameter int blueToYellowSlope = 65472
) (
    input  logic [W+D-1:0] x,
    output logic [23:0]    rgb
);

    localparam int WD = W + D;

    localparam logic [WD-1:0] X_RED    = WD'(HUE_RED << D);
    localparam logic [WD-1:0] X_BLUE   = WD'(HUE_BLUE << D);
    localparam logic [WD-1:0] X_YELLOW = WD'(HUE_YELLOW << D);

    localparam logic [WD-1:0] S_YR = WD'(yellowToRedSlope);
    localparam logic [WD-1:0] S_RB = WD'(redToBlueSlope);
    localparam logic [WD-1:0] S_BY = WD'(blueToYellowSlope);

    // slope and dx each carry D fraction bits, so the product's integer part
    // sits above bit 2D; anything past 255 saturates.
    function automatic logic [7:0] ramp(input logic [WD-1:0] slope, input logic [WD-1:0] dx);
        logic [2*WD-1:0] prod;
        prod = {{WD{1'b0}}, slope} * {{WD{1'b0}}, dx};
        prod = prod >> (2 * D);
        return (|prod[2*WD-1:8]) ? 8'hFF : prod[7:0];
    endfunction

    logic [7:0] t;

    always_comb begin
        t   = '0;
        rgb = '0;
        if (x < X_RED) begin
            t   = ramp(S_YR, x);
            rgb = {8'hFF, 8'hFF - t, 8'h00};
        end else if (x < X_BLUE) begin
            t   = ramp(S_RB, x - X_RED);
            rgb = {8'hFF - t, 8'h00, t};
        end else if (x < X_YELLOW) begin
            t   = ramp(S_BY, x - X_BLUE);
            rgb = {t, t, 8'hFF - t};
        end else begin
            rgb = 24'hFFFF00;
        end
    end

endmodule

// File: rtl/linear_visualizer.sv
// Per-bin note amplitude/position to LED colour and LED share, five-state run
// sequence. Define LINVIS_LED_COUNT_EN to build the per-bin LED count dividers.
module linear_visualizer
    import linvis_pkg::*;
#(
    parameter int W                   = LINVIS_W,
    parameter int D                   = LINVIS_D,
    parameter int LEDS                = 50,
    parameter int BIN_QTY             = 12,
    parameter int steadyBright        = 0,
    parameter int LEDFloor            = 102,
    parameter int LEDLimit            = 1023,
    parameter int SaturationAmplifier = 1638,
    parameter int yellowToRedSlope    = 21824,
    parameter int redToBlueSlope      = 43648,
    parameter int blueToYellowSlope   = 65472
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [W+D-1:0]          noteAmplitudes [BIN_QTY],
    input  logic [W+D-1:0]          notePositions  [BIN_QTY],
    output logic [23:0]             rgb            [BIN_QTY],
    output logic [$clog2(LEDS)-1:0] LEDCounts      [BIN_QTY],
    output logic                    done
);

    localparam int WD = W + D;
    localparam int CW = $clog2(LEDS);
    localparam int SW = WD + $clog2(BIN_QTY);

    localparam logic [WD-1:0] FLOOR = WD'(LEDFloor);
    localparam logic [WD-1:0] LIMIT = WD'(LEDLimit);
    localparam logic [WD-1:0] SAT   = WD'(SaturationAmplifier);

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [WD-1:0] v);
        logic [WD+7:0] p;
        p = {{WD{1'b0}}, c} * {8'h00, v};
        return 8'(p >> D);
    endfunction

    state_t state_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            done      <= 1'b0;
        end else begin
            done <= (state_reg == OUT);
            case (state_reg)
                IDLE:    if (start) state_reg <= CAPTURE;
                CAPTURE: state_reg <= PRE;
                PRE:     state_reg <= CALC;
                CALC:    state_reg <= OUT;
                OUT:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    logic [WD-1:0]      amp_in_reg  [BIN_QTY];
    logic [D-1:0]       pos_reg     [BIN_QTY];
    logic [WD-1:0]      amp_next    [BIN_QTY];
    logic [WD-1:0]      amp_reg     [BIN_QTY];
    logic [WD-1:0]      x_next      [BIN_QTY];
    logic [23:0]        col_next    [BIN_QTY];
    logic [23:0]        col_reg     [BIN_QTY];
    logic [WD-1:0]      bright_next [BIN_QTY];
    logic [WD-1:0]      bright_reg  [BIN_QTY];
    logic [BIN_QTY-1:0] unused_pos_hi;

    generate
        for (genvar gi = 0; gi < BIN_QTY; gi++) begin : g_bin
            logic [2*WD-1:0] sat_prod;

            // Only the fractional part of a position selects the hue.
            assign unused_pos_hi[gi] = ^notePositions[gi][WD-1:D];

            assign amp_next[gi] = (amp_in_reg[gi] > FLOOR) ? amp_in_reg[gi] - FLOOR : '0;
            assign x_next[gi]   = {{W{1'b0}}, pos_reg[gi]} * WD'(HUE_SPAN);

            hue_to_rgb #(
                .W                (W),
                .D                (D),
                .yellowToRedSlope (yellowToRedSlope),
                .redToBlueSlope   (redToBlueSlope),
                .blueToYellowSlope(blueToYellowSlope)
            ) u_hue (
                .x  (x_next[gi]),
                .rgb(col_next[gi])
            );

            assign sat_prod = ({{WD{1'b0}}, amp_reg[gi]} * {{WD{1'b0}}, SAT}) >> D;
            assign bright_next[gi] = ((steadyBright != 0) || (sat_prod > {{WD{1'b0}}, LIMIT}))
                                     ? LIMIT : WD'(sat_prod);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    amp_in_reg[gi] <= '0;
                    pos_reg[gi]    <= '0;
                    amp_reg[gi]    <= '0;
                    col_reg[gi]    <= '0;
                    bright_reg[gi] <= '0;
                    rgb[gi]        <= '0;
                end else begin
                    case (state_reg)
                        IDLE: if (start) begin
                            amp_in_reg[gi] <= noteAmplitudes[gi];
                            pos_reg[gi]    <= notePositions[gi][D-1:0];
                        end
                        PRE:  amp_reg[gi] <= amp_next[gi];
                        CALC: begin
                            col_reg[gi]    <= col_next[gi];
                            bright_reg[gi] <= bright_next[gi];
                        end
                        OUT:  rgb[gi] <= {scale(col_reg[gi][23:16], bright_reg[gi]),
                                          scale(col_reg[gi][15:8],  bright_reg[gi]),
                                          scale(col_reg[gi][7:0],   bright_reg[gi])};
                        default: ;
                    endcase
                end
            end
        end
    endgenerate

`ifdef LINVIS_LED_COUNT_EN
    localparam int NW = WD + $clog2(LEDS + 1);
    localparam int QW = (NW > SW) ? NW : SW;

    logic [SW-1:0] sum_next;
    logic [SW-1:0] sum_reg;

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < BIN_QTY; i++) begin
            sum_next = sum_next + SW'(amp_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= '0;
        end else if (state_reg == PRE) begin
            sum_reg <= sum_next;
        end
    end

    generate
        for (genvar gi = 0; gi < BIN_QTY; gi++) begin : g_count
            logic [QW-1:0] quot;
            logic [CW-1:0] cnt_reg;

            // Every amp is <= sum, so the quotient never exceeds LEDS.
            assign quot = (sum_reg == '0) ? '0
                        : (QW'(amp_reg[gi]) * QW'(LEDS)) / QW'(sum_reg);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg       <= '0;
                    LEDCounts[gi] <= '0;
                end else if (state_reg == CALC) begin
                    cnt_reg <= CW'(quot);
                end else if (state_reg == OUT) begin
                    LEDCounts[gi] <= cnt_reg;
                end
            end
        end
    endgenerate
`else
    generate
        for (genvar gi = 0; gi < BIN_QTY; gi++) begin : g_count
            assign LEDCounts[gi] = '0;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_linear_visualizer.sv
// Scoreboard bench for linear_visualizer: normal and steadyBright instances share
// stimulus; a negedge monitor pops expectations whenever done is seen.
module tb_linear_visualizer;

    localparam int BINS = 12;
    localparam int CW   = 6;

    typedef struct {
        logic [BINS-1:0][23:0]   rgb;
        logic [BINS-1:0][CW-1:0] cnt;
        int                      edge_no;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [15:0]   amps  [BINS];
    logic [15:0]   poss  [BINS];
    logic [23:0]   rgb_n [BINS];
    logic [23:0]   rgb_s [BINS];
    logic [CW-1:0] cnt_n [BINS];
    logic [CW-1:0] cnt_s [BINS];
    logic          done_n;
    logic          done_s;

    int edge_cnt  = 0;
    int errors    = 0;
    int checks    = 0;
    int done_seen = 0;
    exp_t q_n[$];
    exp_t q_s[$];

    logic [15:0] sweep_pos [BINS] = '{16'd0, 16'd256, 16'd512, 16'd640, 16'd767, 16'd768,
                                      16'd800, 16'd938, 16'd939, 16'd511, 16'd1024, 16'd1023};
    logic [23:0] sweep_rgb [BINS] = '{24'hFEFE00, 24'hFE7F00, 24'hFE0000, 24'h7F007E,
                                      24'h0000FD, 24'h0000FE, 24'h2E2ECF, 24'hFDFD00,
                                      24'hFEFE00, 24'hFE0000, 24'hFEFE00, 24'hFEFE00};

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    linear_visualizer dut_n (
        .clk(clk), .rst(rst), .start(start),
        .noteAmplitudes(amps), .notePositions(poss),
        .rgb(rgb_n), .LEDCounts(cnt_n), .done(done_n)
    );

    linear_visualizer #(.steadyBright(1)) dut_s (
        .clk(clk), .rst(rst), .start(start),
        .noteAmplitudes(amps), .notePositions(poss),
        .rgb(rgb_s), .LEDCounts(cnt_s), .done(done_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic compare(input string who, input exp_t e,
                           input logic [23:0] r [BINS], input logic [CW-1:0] c [BINS]);
        check($sformatf("%s done edge", who), edge_cnt, e.edge_no);
        for (int i = 0; i < BINS; i++) begin
            check($sformatf("%s rgb[%0d]", who, i), 32'(r[i]), 32'(e.rgb[i]));
            check($sformatf("%s LEDCounts[%0d]", who, i), 32'(c[i]), 32'(e.cnt[i]));
        end
        $display("txn %s edge=%0d rgb0=%06h rgb1=%06h cnt0=%0d cnt1=%0d",
                 who, edge_cnt, r[0], r[1], c[0], c[1]);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done_n) begin
                done_seen++;
                if (q_n.size() == 0) check("normal unexpected done", 32'(done_n), 32'd0);
                else compare("normal", q_n.pop_front(), rgb_n, cnt_n);
            end
            if (done_s) begin
                done_seen++;
                if (q_s.size() == 0) check("steady unexpected done", 32'(done_s), 32'd0);
                else compare("steady", q_s.pop_front(), rgb_s, cnt_s);
            end
        end
    end

    function automatic logic [CW-1:0] ce(input int v);
`ifdef LINVIS_LED_COUNT_EN
        return CW'(v);
`else
        return (v > 0) ? '0 : '0;
`endif
    endfunction

    function automatic exp_t fill(input logic [23:0] r, input logic [CW-1:0] c);
        exp_t e;
        for (int i = 0; i < BINS; i++) begin
            e.rgb[i] = r;
            e.cnt[i] = c;
        end
        e.edge_no = 0;
        return e;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < BINS; i++) begin
            amps[i] = '0;
            poss[i] = '0;
        end
    endtask

    task automatic issue(input exp_t en, input exp_t es);
        @(negedge clk);
        start = 1'b1;
        en.edge_no = edge_cnt + 1 + 4;
        es.edge_no = edge_cnt + 1 + 4;
        q_n.push_back(en);
        q_s.push_back(es);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        for (int i = 0; i < BINS; i++) begin
            check($sformatf("%s normal rgb[%0d]", tag, i), 32'(rgb_n[i]), 32'd0);
            check($sformatf("%s steady rgb[%0d]", tag, i), 32'(rgb_s[i]), 32'd0);
            check($sformatf("%s normal LEDCounts[%0d]", tag, i), 32'(cnt_n[i]), 32'd0);
        end
        check($sformatf("%s normal done", tag), 32'(done_n), 32'd0);
        check($sformatf("%s steady done", tag), 32'(done_s), 32'd0);
    endtask

    initial begin
        exp_t en, es;
        int base, s;
        clear_inputs();
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // all amplitudes zero
        issue(fill(24'h000000, '0), fill(24'hFEFE00, '0));

        // single loud bin at hue 0
        amps[0] = 16'd1024;
        en = fill(24'h000000, '0); en.rgb[0] = 24'hFEFE00; en.cnt[0] = ce(50);
        es = fill(24'hFEFE00, '0); es.cnt[0] = ce(50);
        issue(en, es);

        // two equal bins, second at pure red
        clear_inputs();
        amps[0] = 16'd2048; amps[1] = 16'd2048; poss[1] = 16'd512;
        en = fill(24'h000000, '0);
        en.rgb[0] = 24'hFEFE00; en.rgb[1] = 24'hFE0000; en.cnt[0] = ce(25); en.cnt[1] = ce(25);
        es = fill(24'hFEFE00, '0);
        es.rgb[1] = 24'hFE0000; es.cnt[0] = ce(25); es.cnt[1] = ce(25);
        issue(en, es);

        // dim and mid brightness, and an amplitude below the floor
        clear_inputs();
        amps[0] = 16'd110; amps[1] = 16'd300; amps[2] = 16'd50;
        en = fill(24'h000000, '0);
        en.rgb[0] = 24'h020200; en.rgb[1] = 24'h4E4E00; en.cnt[0] = ce(1); en.cnt[1] = ce(48);
        es = fill(24'hFEFE00, '0); es.cnt[0] = ce(1); es.cnt[1] = ce(48);
        issue(en, es);

        // hue sweep across every segment and its boundaries
        clear_inputs();
        en = fill(24'h000000, ce(4));
        for (int i = 0; i < BINS; i++) begin
            amps[i] = 16'd2048;
            poss[i] = sweep_pos[i];
            en.rgb[i] = sweep_rgb[i];
        end
        issue(en, en);

        // reset while a run is in flight
        clear_inputs();
        amps[0] = 16'd2048; amps[1] = 16'd2048; poss[1] = 16'd512;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_cleared("midrun");
        base = done_seen;
        @(negedge clk); rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midrun no done pulse", done_seen, base);

        // start held for ten cycles: two back-to-back runs
        en = fill(24'h000000, '0);
        en.rgb[0] = 24'hFEFE00; en.rgb[1] = 24'hFE0000; en.cnt[0] = ce(25); en.cnt[1] = ce(25);
        es = fill(24'hFEFE00, '0);
        es.rgb[1] = 24'hFE0000; es.cnt[0] = ce(25); es.cnt[1] = ce(25);
        @(negedge clk);
        start = 1'b1;
        s = edge_cnt + 1;
        en.edge_no = s + 4; es.edge_no = s + 4;
        q_n.push_back(en); q_s.push_back(es);
        en.edge_no = s + 9; es.edge_no = s + 9;
        q_n.push_back(en); q_s.push_back(es);
        repeat (10) @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);

        for (int k = 0; k < 20 && (q_n.size() != 0 || q_s.size() != 0); k++) @(negedge clk);
        check("normal pending results", 32'(q_n.size()), 32'd0);
        check("steady pending results", 32'(q_s.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/linear_visualizer.md
LINEAR_VISUALIZER -- requirements
Module: linear_visualizer

Interface
REQ-001 SHALL have parameter W, default 6, meaning whole bits of the unsigned W.D fixed-point format.
REQ-002 SHALL have parameter D, default 10, meaning fraction bits.
REQ-003 SHALL have parameter LEDS, default 50, meaning LED strip length.
REQ-004 SHALL have parameter BIN_QTY, default 12, meaning number of note bins.
REQ-005 SHALL have parameter steadyBright, default 0, meaning force full brightness when 1.
REQ-006 SHALL have parameters LEDFloor 102, LEDLimit 1023 and SaturationAmplifier 1638, all in W.D format.
REQ-007 SHALL have parameters yellowToRedSlope 21824, redToBlueSlope 43648 and blueToYellowSlope 65472, all in W.D format.
REQ-008 SHALL have clock port clk, input, 1 bit. There is one clock.
REQ-009 SHALL have reset port rst, input, 1 bit. Reset is asynchronous and active-high.
REQ-010 SHALL have input start, 1 bit, level request to run.
REQ-011 SHALL have input noteAmplitudes, [BIN_QTY][W+D], carrying per-bin amplitude.
REQ-012 SHALL have input notePositions, [BIN_QTY][W+D], carrying per-bin position; only bits [D-1:0] are used.
REQ-013 SHALL have output rgb, [BIN_QTY][24], with R in [23:16], G in [15:8] and B in [7:0].
REQ-014 SHALL have output LEDCounts, [BIN_QTY][$clog2(LEDS)], giving LEDs per bin.
REQ-015 SHALL have output done, 1 bit, a one-cycle result-valid pulse.

Function
REQ-016 SHALL have states IDLE, CAPTURE, PRE, CALC and OUT. From IDLE, start=1 at a clk edge moves to CAPTURE and registers both input arrays. Each following edge advances one state, and OUT returns to IDLE.
REQ-017 SHALL ignore start outside IDLE. If start is held high, a new run is accepted on the edge after OUT (back-to-back runs).
REQ-018 SHALL, in PRE, compute per-bin amp_i = max(noteAmplitudes_i - LEDFloor, 0) as a saturating subtract.
REQ-019 SHALL, in PRE, compute sum = Σ amp_i with width W+D+$clog2(BIN_QTY), so it never overflows.
REQ-020 SHALL, in CALC, compute hue position x_i = pos_i[D-1:0] × 24 in W.D format.
REQ-021 SHALL map x to colour, with each channel = min(floor(slope × dx / 2^(2D)), 255):
- x<12: R=255, G=255−ch(yellowToRedSlope, x), B=0.
- 12≤x<18: R=255−ch(redToBlueSlope, x−12), G=0, B=ch(redToBlueSlope, x−12).
- 18≤x<22: R=G=ch(blueToYellowSlope, x−18), B=255−R.
- x≥22: R=G=255, B=0.
REQ-022 SHALL compute brightness v_i = LEDLimit if steadyBright=1, else min((amp_i × SaturationAmplifier) >> D, LEDLimit).
REQ-023 SHALL compute each output channel = (colour channel × v_i) >> D, truncated to 8 bits.
REQ-024 SHALL compute LEDCounts_i = floor(amp_i × LEDS / sum) when sum≠0. All counts SHALL be 0 when sum=0.
REQ-025 SHALL register rgb and LEDCounts in OUT and assert done for exactly that cycle. Latency from the start-sampling edge to done is 4 edges.
REQ-026 SHALL hold rgb and LEDCounts stable between runs, until the next OUT.

Reset
REQ-027 SHALL, on rst=1 (asynchronous, at any time, including mid-run), clear rgb, LEDCounts and done to 0, go to IDLE, and clear all pipeline registers.
REQ-028 SHALL, after rst deasserts, start nothing until start is sampled high in IDLE.

Configuration
REQ-029 SHALL, with LINVIS_LED_COUNT_EN defined, implement REQ-024.
REQ-030 SHALL, without LINVIS_LED_COUNT_EN, omit the divider logic, tie LEDCounts to 0, and leave all other behaviour and latency unchanged.

Structure
REQ-031 SHALL place fixed-point width localparams, the state enum, and colour segment boundaries (12, 18, 22) in shared package linvis_pkg.
REQ-032 SHALL use one sub-module, hue_to_rgb, which is combinational, maps position to unscaled RGB, and is instantiated BIN_QTY times.

Verification
REQ-033 SHALL verify: rst asserted mid-run -> rgb=0, LEDCounts=0, done=0 immediately, with no done pulse.
REQ-034 SHALL verify: all amplitudes 0, start for 1 cycle -> done pulses exactly 4 edges later; all LEDCounts=0 and all rgb=0.
REQ-035 SHALL verify: bin0 amplitude 1024 with position 0, others 0 -> LEDCounts[0]=50 (others 0), rgb[0]=24'hFEFE00.
REQ-036 SHALL verify: bins 0 and 1 amplitude 2048, bin1 position 512, others 0 -> LEDCounts 25/25, rgb[0]=24'hFEFE00, rgb[1]=24'hFE0000.
REQ-037 SHALL verify: start held high for 10 cycles -> done pulses on the 4th and 9th edges after the first sample; start in busy states is ignored.
REQ-038 SHALL verify: steadyBright=1 with bin0 amplitude 110 -> rgb[0]=24'hFEFE00.
